// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Walks a binary index from a captured first value to a captured last
//   value (modulo 2^WIDTH) and presents each index with its Gray code on a
//   valid/ready output stream. It can run once, or run continuously when
//   wrap is set.
//
// Parameters
//   WIDTH      index / Gray code width (2..16)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begin a sequence (sampled in IDLE; stop has priority)
//   stop       abort the running sequence (sampled in RUN)
//   first      first index, captured on accepted start
//   last       final index, captured on accepted start
//   wrap       continuous mode, captured on accepted start
//   out_valid  beat available (high in RUN)
//   out_ready  downstream accepts the beat
//   out_bin    current binary index
//   out_gray   Gray code of out_bin, registered together with it
//   busy       high in RUN
//   done       one-cycle pulse when a non-wrapping sequence completes
//   beat_cnt   accepted beats since last start, saturating at all-ones
//   gray_err   (only with GRAY_SEQ_CHECK_EN) sticky Gray/binary mismatch flag
//
// Optional feature macro: GRAY_SEQ_CHECK_EN
module gray_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] last,
  input  logic             wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   beat_cnt
`ifdef GRAY_SEQ_CHECK_EN
  ,
  output logic             gray_err
`endif
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_first;
  logic [WIDTH-1:0] r_last;
  logic             r_wrap;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH:0]   r_beat;
  logic             r_done;

  logic             w_start_acc;
  logic             w_beat_acc;
  logic             w_stop_run;
  logic             w_at_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;

  assign w_start_acc = (r_state == S_IDLE) && start && !stop;
  assign w_beat_acc  = (r_state == S_RUN) && out_ready;
  assign w_stop_run  = (r_state == S_RUN) && stop;
  assign w_at_last   = (r_bin == r_last);
  // Normal completion: last index accepted, not wrapping, not aborted.
  assign w_finish    = w_beat_acc && !stop && w_at_last && !r_wrap;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_stop_run || w_finish) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = (r_state == S_RUN);
    busy      = (r_state == S_RUN);
    done      = r_done;
    out_bin   = r_bin;
    out_gray  = r_gray;
    beat_cnt  = r_beat;
  end

  // Next index; Gray is computed from it so both registers update together.
  // On stop or completion the index holds its last presented value.
  always_comb begin
    w_bin_next = r_bin;
    if (w_start_acc) begin
      w_bin_next = first;
    end else if (w_beat_acc && !stop) begin
      if (!w_at_last) begin
        w_bin_next = WIDTH'(r_bin + 1'b1);
      end else if (r_wrap) begin
        w_bin_next = r_first;
      end
    end
    w_gray_next = w_bin_next ^ (w_bin_next >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first <= '0;
      r_last  <= '0;
      r_wrap  <= 1'b0;
      r_bin   <= '0;
      r_gray  <= '0;
      r_beat  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_done <= w_finish;
      if (w_start_acc) begin
        r_first <= first;
        r_last  <= last;
        r_wrap  <= wrap;
        r_beat  <= '0;
      end else if (w_beat_acc && (r_beat != '1)) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

`ifdef GRAY_SEQ_CHECK_EN
  // Decode Gray back to binary by prefix XOR from the MSB.
  logic [WIDTH-1:0] w_dec;

  always_comb begin
    w_dec = '0;
    w_dec[WIDTH-1] = r_gray[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      w_dec[WIDTH-1-i] = w_dec[WIDTH-i] ^ r_gray[WIDTH-1-i];
    end
  end

  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if ((r_state == S_RUN) && (w_dec != r_bin)) begin
      r_err <= 1'b1;
    end
  end

  assign gray_err = r_err;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl (WIDTH=4). The expected beat stream
// is computed arithmetically: beat k of a sequence is
// (first + k mod len) mod 16, with len = ((last-first) mod 16)+1.
module tb_gray_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] first;
  logic [3:0] last;
  logic       wrap;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bin;
  logic [3:0] out_gray;
  logic       busy;
  logic       done;
  logic [4:0] beat_cnt;
`ifdef GRAY_SEQ_CHECK_EN
  logic       gray_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .first     (first),
    .last      (last),
    .wrap      (wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt)
`ifdef GRAY_SEQ_CHECK_EN
    ,
    .gray_err  (gray_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_err();
`ifdef GRAY_SEQ_CHECK_EN
    check("gray_err", 32'(gray_err), 0);
`endif
  endtask

  function automatic int gray_of(input int v);
    return (v ^ (v >> 1)) & 15;
  endfunction

  // Runs one sequence. Called at a negedge with the DUT idle (or in its done
  // cycle). rmode: 0 ready always, 1 random ready, 2 pattern 1,0,0,1,0,1.
  // stop_after>0 asserts stop in the cycle the stop_after-th beat is accepted.
  // poke=1 pulses start (with a different first) while running.
  task automatic run(input int f, input int l, input bit w, input int rmode,
                     input int stop_after, input bit poke);
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int len, k, cyc, ev;
    bit fin, rdy, stopnow;
    len = ((l - f + 16) % 16) + 1;
    first = 4'(f); last = 4'(l); wrap = w;
    start = 1'b1; stop = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0; cyc = 0; fin = 1'b0; ev = f;
    while (!fin && cyc < 300) begin
      ev = (f + (k % len)) % 16;
      check("valid", 32'(out_valid), 1);
      check("busy", 32'(busy), 1);
      check("done_low", 32'(done), 0);
      check("bin", 32'(out_bin), ev);
      check("gray", 32'(out_gray), gray_of(ev));
      check("beat_cnt", 32'(beat_cnt), (k > 31) ? 31 : k);
      check_err();
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom % 4) != 0;
        default: rdy = (cyc < 6) ? pat[cyc] : 1'b1;
      endcase
      out_ready = rdy;
      if (poke && cyc == 1) begin
        start = 1'b1;
        first = 4'($urandom);
      end
      if (rdy) k++;
      stopnow = (stop_after > 0) && rdy && (k == stop_after);
      stop = stopnow;
      @(negedge clk);
      start = 1'b0; stop = 1'b0; out_ready = 1'b0;
      cyc++;
      if (stopnow) begin
        check("stop_valid", 32'(out_valid), 0);
        check("stop_busy", 32'(busy), 0);
        check("stop_nodone", 32'(done), 0);
        check("stop_beat", 32'(beat_cnt), (k > 31) ? 31 : k);
        check("stop_bin", 32'(out_bin), ev);
        check("stop_gray", 32'(out_gray), gray_of(ev));
        fin = 1'b1;
      end else if (!w && rdy && k == len) begin
        check("end_valid", 32'(out_valid), 0);
        check("end_busy", 32'(busy), 0);
        check("end_done", 32'(done), 1);
        check("end_beat", 32'(beat_cnt), len);
        fin = 1'b1;
      end
    end
    check("timeout", 32'(fin), 1);
  endtask

  initial begin
    int f, l, sa;
    bit w;
    rst = 1'b1; start = 1'b0; stop = 1'b0; first = '0; last = '0;
    wrap = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bin", 32'(out_bin), 0);
    check("rst_gray", 32'(out_gray), 0);
    check("rst_beat", 32'(beat_cnt), 0);
    check_err();
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    run(0, 15, 1'b0, 0, 0, 1'b0);   // full sweep
    @(negedge clk);
    check("done_1cyc", 32'(done), 0);
    run(3, 5, 1'b0, 2, 0, 1'b0);    // backpressure
    run(14, 1, 1'b0, 0, 0, 1'b0);   // modulo wrap
    run(2, 3, 1'b1, 0, 5, 1'b0);    // continuous + stop after 5

    // start together with stop in IDLE: stop wins
    first = 4'd6; last = 4'd8; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 0);
    check("ss_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("ss_busy2", 32'(busy), 0);

    run(7, 7, 1'b0, 0, 0, 1'b0);    // single beat, start accepted in done cycle next
    run(4, 10, 1'b0, 1, 0, 1'b1);   // start during RUN ignored
    run(9, 9, 1'b1, 1, 40, 1'b0);   // repeated value, beat_cnt saturation

    // Randomized sequences
    for (int i = 0; i < 8; i++) begin
      f  = int'($urandom % 16);
      l  = int'($urandom % 16);
      w  = 1'($urandom % 2);
      sa = w ? int'(1 + $urandom % 24) : (($urandom % 3 == 0) ? int'(1 + $urandom % 16) : 0);
      run(f, l, w, 1, sa, 1'($urandom % 2));
    end

    // Async reset between clock edges while running
    @(negedge clk);
    first = 4'd5; last = 4'd12; wrap = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_bin", 32'(out_bin), 0);
    check("arst_gray", 32'(out_gray), 0);
    check("arst_beat", 32'(beat_cnt), 0);
    check("arst_done", 32'(done), 0);
    check_err();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_valid", 32'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
